// File: rtl/servo_pkg.sv
// Shared steering constants and helpers for the multi-channel servo PWM block.
// Direction codes are those of the original single-channel steering driver.
package servo_pkg;

    typedef enum logic [2:0] {
        DirStraight   = 3'b000,
        DirLeftSmall  = 3'b001,
        DirLeftBig    = 3'b011,
        DirRightSmall = 3'b101,
        DirRightBig   = 3'b111
    } dir_e;

    localparam int unsigned WIDTH_STRAIGHT    = 1450;
    localparam int unsigned WIDTH_LEFT_SMALL  = 1750;
    localparam int unsigned WIDTH_LEFT_BIG    = 1950;
    localparam int unsigned WIDTH_RIGHT_SMALL = 1150;
    localparam int unsigned WIDTH_RIGHT_BIG   = 950;

    function automatic logic [31:0] clamp_width(input logic [31:0] w, input logic [31:0] lo,
                                                 input logic [31:0] hi);
        if (w < lo) return lo;
        if (w > hi) return hi;
        return w;
    endfunction

    function automatic logic [31:0] dir_to_width(input dir_e dir);
        case (dir)
            DirLeftSmall:  return WIDTH_LEFT_SMALL;
            DirLeftBig:    return WIDTH_LEFT_BIG;
            DirRightSmall: return WIDTH_RIGHT_SMALL;
            DirRightBig:   return WIDTH_RIGHT_BIG;
            default:       return WIDTH_STRAIGHT;
        endcase
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: target/active width registers, per-frame slew limiting and
// the frame-aligned enable.
module servo_slew_ch #(
    parameter int unsigned CNT_W     = 13,
    parameter int unsigned W_DEFAULT = 1450,
    parameter int unsigned STEP      = 50
) (
    input  logic             clkus,
    input  logic             rst,
    input  logic             boundary,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_width,
    input  logic             enable,
    output logic [CNT_W-1:0] active,
    output logic             en_q,
    output logic             settled
);

    localparam logic signed [CNT_W:0] STEP_S = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0]      STEP_U = CNT_W'(STEP);

    logic [CNT_W-1:0]      target_q;
    logic [CNT_W-1:0]      active_q;
    logic [CNT_W-1:0]      active_d;
    logic signed [CNT_W:0] diff;

    // One extra bit keeps the signed difference from wrapping.
    always_comb begin
        diff     = $signed({1'b0, target_q}) - $signed({1'b0, active_q});
        active_d = target_q;
        if (STEP != 0 && diff > STEP_S) begin
            active_d = active_q + STEP_U;
        end else if (STEP != 0 && diff < -STEP_S) begin
            active_d = active_q - STEP_U;
        end
    end

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            target_q <= CNT_W'(W_DEFAULT);
            active_q <= CNT_W'(W_DEFAULT);
            en_q     <= 1'b0;
        end else begin
            if (wr) begin
                target_q <= wr_width;
            end
            if (boundary) begin
                active_q <= active_d;
                en_q     <= enable;
            end
        end
    end

    assign active  = active_q;
    assign settled = (active_q == target_q);

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter, write decode and
// per-channel pulse compare around slew-limited channel registers.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 13,
    parameter int unsigned PERIOD    = 5000,
    parameter int unsigned W_MIN     = 900,
    parameter int unsigned W_MAX     = 2000,
    parameter int unsigned W_DEFAULT = 1450,
    parameter int unsigned STEP      = 50,
    parameter int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clkus,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_width,
    input  logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start,
    output logic [CHANNELS-1:0] settled
);

    logic [CNT_W-1:0]    cnt;
    logic                boundary;
    logic [CNT_W-1:0]    wr_clamped;
    logic [CHANNELS-1:0] en_q;
    logic [CNT_W-1:0]    active [CHANNELS];

    assign boundary   = (cnt == CNT_W'(PERIOD - 1));
    assign wr_clamped = CNT_W'(clamp_width(32'(wr_width), W_MIN, W_MAX));

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= boundary ? '0 : cnt + CNT_W'(1);
            frame_start <= boundary;
        end
    end

    // Out-of-range channel indices match no channel and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_en && (32'(wr_ch) == 32'(i));

        servo_slew_ch #(
            .CNT_W     (CNT_W),
            .W_DEFAULT (W_DEFAULT),
            .STEP      (STEP)
        ) u_ch (
            .clkus    (clkus),
            .rst      (rst),
            .boundary (boundary),
            .wr       (wr_hit),
            .wr_width (wr_clamped),
            .enable   (enable[i]),
            .active   (active[i]),
            .en_q     (en_q[i]),
            .settled  (settled[i])
        );
    end

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= en_q[i] && (cnt < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: a frame-level model predicts each frame's
// pulse widths; a monitor measures pulses between frame_start pulses and compares.
module tb_servo_pwm_multi;

    localparam int CH     = 6;
    localparam int CH_W   = 3;
    localparam int CNT_W  = 13;
    localparam int P      = 2200;
    localparam int W_MIN  = 900;
    localparam int W_MAX  = 2000;
    localparam int W_DEF  = 1450;
    localparam int STEP   = 50;
    localparam logic [CH-1:0] ALL = '1;

    logic             clkus    = 1'b0;
    logic             rst      = 1'b1;
    logic             wr_en    = 1'b0;
    logic [CH_W-1:0]  wr_ch    = '0;
    logic [CNT_W-1:0] wr_width = '0;
    logic [CH-1:0]    enable   = '0;
    logic [CH-1:0]    pwm;
    logic [CH-1:0]    settled;
    logic             frame_start;

    always #5 clkus = ~clkus;

    servo_pwm_multi #(
        .CHANNELS  (CH),
        .CNT_W     (CNT_W),
        .PERIOD    (P),
        .W_MIN     (W_MIN),
        .W_MAX     (W_MAX),
        .W_DEFAULT (W_DEF),
        .STEP      (STEP)
    ) dut (
        .clkus       (clkus),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_width    (wr_width),
        .enable      (enable),
        .pwm         (pwm),
        .frame_start (frame_start),
        .settled     (settled)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level reference model
    typedef logic [CH-1:0][15:0] exp_t;
    exp_t expq[$];
    exp_t mexp;
    int   mcnt;
    int   mtarget[CH];
    int   mactive[CH];
    bit   men[CH];

    function automatic int clampw(input int w);
        if (w < W_MIN) return W_MIN;
        if (w > W_MAX) return W_MAX;
        return w;
    endfunction

    initial forever begin
        @(posedge clkus or posedge rst);
        if (rst) begin
            mcnt = 0;
            for (int i = 0; i < CH; i++) begin
                mtarget[i] = W_DEF;
                mactive[i] = W_DEF;
                men[i]     = 1'b0;
            end
            expq.delete();
            expq.push_back('0);
        end else begin
            if (mcnt == P - 1) begin
                for (int i = 0; i < CH; i++) begin
                    int d;
                    d = mtarget[i] - mactive[i];
                    if (d <= STEP && d >= -STEP) mactive[i] = mtarget[i];
                    else if (d > 0) mactive[i] = mactive[i] + STEP;
                    else mactive[i] = mactive[i] - STEP;
                    men[i]  = enable[i];
                    mexp[i] = men[i] ? 16'(mactive[i]) : 16'd0;
                end
                expq.push_back(mexp);
            end
            if (wr_en && int'(wr_ch) < CH) mtarget[int'(wr_ch)] = clampw(int'(wr_width));
            mcnt = (mcnt == P - 1) ? 0 : mcnt + 1;
        end
    end

    // Monitor: measure each frame, compare against the scoreboard at frame_start
    int   cyc;
    int   hi[CH];
    int   meas_last[CH];
    int   frame_no = 0;
    bit   have_fs;
    exp_t got;

    initial forever begin
        @(negedge clkus);
        if (rst) begin
            cyc     = 0;
            have_fs = 1'b0;
            for (int i = 0; i < CH; i++) hi[i] = 0;
        end else begin
            if (frame_start) begin
                if (have_fs) check("frame_period", cyc, P);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: got frame_start with no expectation queued");
                end else begin
                    got = expq.pop_front();
                    for (int i = 0; i < CH; i++)
                        check($sformatf("width_ch%0d_frame%0d", i, frame_no), hi[i], int'(got[i]));
                end
                for (int i = 0; i < CH; i++) begin
                    check($sformatf("settled_ch%0d_frame%0d", i, frame_no), int'(settled[i]),
                          int'(mtarget[i] == mactive[i]));
                    meas_last[i] = hi[i];
                    hi[i]        = 0;
                end
                have_fs = 1'b1;
                cyc     = 0;
                frame_no++;
            end
            cyc++;
            for (int i = 0; i < CH; i++) hi[i] += int'(pwm[i]);
        end
    end

    task automatic tick();
        @(negedge clkus);
        #1;
    endtask

    task automatic wait_mcnt(input int c);
        int n = 0;
        while (mcnt != c && n < 3 * P) begin
            tick();
            n++;
        end
        if (mcnt != c) begin
            checks++;
            failures++;
            $display("FAIL wait_cnt: got cnt %0d expected %0d within budget", mcnt, c);
        end
    endtask

    task automatic wait_frame(input int n);
        int budget = 3 * P * (n - frame_no + 1);
        while (frame_no < n && budget > 0) begin
            tick();
            budget--;
        end
        if (frame_no < n) begin
            checks++;
            failures++;
            $display("FAIL wait_frame: got frame %0d expected %0d within budget", frame_no, n);
        end
    endtask

    task automatic do_write(input int ch, input int w);
        wr_ch    = CH_W'(ch);
        wr_width = CNT_W'(w);
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
    endtask

    int base;

    initial begin
        repeat (3) tick();
        check("reset_pwm", int'(pwm), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_settled", int'(settled), int'(ALL));
        rst    = 1'b0;
        enable = ALL;

        // Slew, clamp, last-write-wins and boundary-cycle write
        wait_frame(3);
        do_write(0, 1200);
        do_write(0, 1950);
        do_write(1, 100);
        do_write(2, 4000);
        wait_mcnt(P - 1);
        do_write(3, 950);
        wait_frame(5);
        check("slew_ch0_first", meas_last[0], 1500);
        check("slew_ch1_first", meas_last[1], 1400);
        check("slew_ch2_first", meas_last[2], 1500);
        check("bnd_write_ch3_hold", meas_last[3], 1450);
        check("unsettled_ch0", int'(settled[0]), 0);
        wait_frame(6);
        check("bnd_write_ch3_step", meas_last[3], 1400);
        check("slew_ch0_second", meas_last[0], 1550);
        wait_frame(15);
        check("final_ch0", meas_last[0], 1950);
        check("clamp_low_ch1", meas_last[1], 900);
        check("clamp_high_ch2", meas_last[2], 2000);
        check("final_ch3", meas_last[3], 950);
        check("untouched_ch4", meas_last[4], 1450);
        check("all_settled", int'(settled), int'(ALL));

        // Mid-pulse disable and out-of-range channel writes
        wait_mcnt(700);
        enable = ALL & ~CH'(1);
        do_write(6, 1200);
        do_write(7, 1300);
        wait_frame(16);
        check("disable_pulse_intact", meas_last[0], 1950);
        wait_frame(17);
        check("disabled_ch0", meas_last[0], 0);
        check("bad_ch_ignored_ch1", meas_last[1], 900);
        check("bad_ch_settled", int'(settled), int'(ALL));

        // Random writes and enables
        repeat (4 * P) begin
            wr_en = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                wr_ch    = CH_W'($urandom_range(0, 7));
                wr_width = CNT_W'($urandom_range(0, 8191));
                wr_en    = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) enable = CH'($urandom);
            tick();
        end
        wr_en  = 1'b0;
        enable = ALL;
        wait_frame(frame_no + 2);

        // Reset during pulses
        wait_mcnt(800);
        check("pre_reset_pwm", int'(pwm), int'(ALL));
        rst = 1'b1;
        #1;
        check("async_reset_pwm", int'(pwm), 0);
        check("async_reset_frame_start", int'(frame_start), 0);
        check("async_reset_settled", int'(settled), int'(ALL));
        repeat (3) tick();
        rst  = 1'b0;
        base = frame_no;
        wait_frame(base + 1);
        for (int i = 0; i < CH; i++) check($sformatf("post_reset_off_ch%0d", i), meas_last[i], 0);
        wait_frame(base + 2);
        for (int i = 0; i < CH; i++)
            check($sformatf("post_reset_default_ch%0d", i), meas_last[i], W_DEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
